// File: rtl/openhw_ahb_manager_pkg.sv
// Shared definitions for the AHB-Lite manager.
//   cvw_t               configuration record (physical address width, data width)
//   CVW_DEFAULT         32-bit address / 32-bit data configuration
//   AHB_* constants     HTRANS / HBURST / HPROT encodings driven by the manager
//   mgr_state_t         manager state, encoded directly as {AValid, DValid}
package openhw_ahb_manager_pkg;

    typedef struct packed {
        int PA_BITS;
        int XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 32, XLEN: 32};

    localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] AHB_HBURST_SINGLE = 3'b000;
    localparam logic [3:0] AHB_HPROT_DATA    = 4'b0011;

    // The state is never stored separately: it is the pair of stage valid bits.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b10,
        PIPE = 2'b11,
        DATA = 2'b01
    } mgr_state_t;

    function automatic mgr_state_t mgr_state(input logic a_valid, input logic d_valid);
        return mgr_state_t'({a_valid, d_valid});
    endfunction

endpackage

// File: rtl/openhw_ahb_manager_flopenr.sv
// Flop primitive with enable and asynchronous active-low reset to zero.
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   en     load enable
//   d / q  data in / registered data out
module openhw_ahb_manager_flopenr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/openhw_ahb_manager.sv
// Single-manager AHB-Lite initiator. A valid/ready request stream is turned
// into pipelined single transfers: the address phase of one transfer overlaps
// the data phase of the previous one, so zero-wait subordinates see one
// transfer per cycle. Each completed transfer returns a registered response.
//   HCLK / HRESETn            bus clock, asynchronous active-low reset
//   Req*                      client request stream (valid/ready)
//   Rsp*                      one-cycle response pulse per accepted request
//   ErrSticky / ErrClr        sticky error flag and its clear
//   H* outputs / H* inputs    AHB-Lite manager interface
module openhw_ahb_manager
    import openhw_ahb_manager_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [P.PA_BITS-1:0]   ReqAddr,
    input  logic                   ReqWrite,
    input  logic [2:0]             ReqSize,
    input  logic [P.XLEN-1:0]      ReqWData,
    input  logic [P.XLEN/8-1:0]    ReqStrb,
    output logic                   RspValid,
    output logic [P.XLEN-1:0]      RspRData,
    output logic                   RspErr,
    output logic                   ErrSticky,
    input  logic                   ErrClr,
    output logic [P.PA_BITS-1:0]   HADDR,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic                   HMASTLOCK,
    output logic [P.XLEN-1:0]      HWDATA,
    output logic [P.XLEN/8-1:0]    HWSTRB,
    input  logic                   HREADY,
    input  logic [P.XLEN-1:0]      HRDATA,
    input  logic                   HRESP
);

    localparam int AW   = P.PA_BITS;
    localparam int XW   = P.XLEN;
    localparam int SW   = P.XLEN / 8;
    localparam int AP_W = AW + 1 + 3 + XW + SW;
    localparam int DP_W = 1 + XW + SW;

    // Address stage
    logic              a_valid_reg;
    logic [AP_W-1:0]   a_payload_reg;
    logic [AW-1:0]     a_addr_reg;
    logic              a_write_reg;
    logic [2:0]        a_size_reg;
    logic [XW-1:0]     a_wdata_reg;
    logic [SW-1:0]     a_strb_reg;

    // Data stage
    logic              d_valid_reg;
    logic [DP_W-1:0]   d_payload_reg;
    logic              d_write_reg;
    logic [XW-1:0]     d_wdata_reg;
    logic [SW-1:0]     d_strb_reg;

    // Response
    logic              rsp_valid_reg;
    logic              rsp_err_reg;
    logic [XW-1:0]     rsp_rdata_reg;
    logic [XW-1:0]     rsp_rdata_next;
    logic              err_sticky_reg;
    logic              err_sticky_next;

    logic              accept;
    logic              complete;
    logic              wr_data_phase;
    mgr_state_t        state;

    assign state    = mgr_state(a_valid_reg, d_valid_reg);
    assign ReqReady = ~a_valid_reg | HREADY;
    assign accept   = ReqValid & ReqReady;
    assign complete = d_valid_reg & HREADY;

    // The address stage may load while HREADY is low as long as it is empty;
    // an occupied address stage only moves when the bus is ready.
    openhw_ahb_manager_flopenr #(.WIDTH(1)) u_a_valid (
        .clk(HCLK), .rst_n(HRESETn), .en(ReqReady),
        .d(accept), .q(a_valid_reg)
    );

    openhw_ahb_manager_flopenr #(.WIDTH(AP_W)) u_a_payload (
        .clk(HCLK), .rst_n(HRESETn), .en(accept),
        .d({ReqAddr, ReqWrite, ReqSize, ReqWData, ReqStrb}), .q(a_payload_reg)
    );

    assign {a_addr_reg, a_write_reg, a_size_reg, a_wdata_reg, a_strb_reg} = a_payload_reg;

    openhw_ahb_manager_flopenr #(.WIDTH(1)) u_d_valid (
        .clk(HCLK), .rst_n(HRESETn), .en(HREADY),
        .d(a_valid_reg), .q(d_valid_reg)
    );

    openhw_ahb_manager_flopenr #(.WIDTH(DP_W)) u_d_payload (
        .clk(HCLK), .rst_n(HRESETn), .en(HREADY),
        .d({a_write_reg, a_wdata_reg, a_strb_reg}), .q(d_payload_reg)
    );

    assign {d_write_reg, d_wdata_reg, d_strb_reg} = d_payload_reg;

    // Read data is only returned for an error-free read; writes and errors give 0.
    assign rsp_rdata_next  = (complete & ~d_write_reg & ~HRESP) ? HRDATA : '0;
    // A set in the same cycle as a clear wins.
    assign err_sticky_next = (complete & HRESP) | (err_sticky_reg & ~ErrClr);

    openhw_ahb_manager_flopenr #(.WIDTH(XW + 3)) u_rsp (
        .clk(HCLK), .rst_n(HRESETn), .en(1'b1),
        .d({complete, complete & HRESP, rsp_rdata_next, err_sticky_next}),
        .q({rsp_valid_reg, rsp_err_reg, rsp_rdata_reg, err_sticky_reg})
    );

    assign RspValid  = rsp_valid_reg;
    assign RspErr    = rsp_err_reg;
    assign RspRData  = rsp_rdata_reg;
    assign ErrSticky = err_sticky_reg;

    // Bus address phase
    assign HTRANS    = ((state == ADDR) || (state == PIPE)) ? AHB_HTRANS_NONSEQ : AHB_HTRANS_IDLE;
    assign HADDR     = a_addr_reg;
    assign HWRITE    = a_write_reg;
    assign HSIZE     = a_size_reg;
    assign HBURST    = AHB_HBURST_SINGLE;
    assign HPROT     = AHB_HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    // Bus data phase: write data lanes are driven only while a write is in
    // the data stage, otherwise they read as zero.
    assign wr_data_phase = ((state == PIPE) || (state == DATA)) & d_write_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lane
            assign HWDATA[gi*8 +: 8] = wr_data_phase ? d_wdata_reg[gi*8 +: 8] : 8'h00;
            assign HWSTRB[gi]        = wr_data_phase & d_strb_reg[gi];
        end
    endgenerate

endmodule

// File: doc/openhw_ahb_manager.md
# openhw_ahb_manager

Single-manager AHB-Lite initiator that converts a simple valid/ready request stream into pipelined AHB transfers and returns a registered response per transfer. It sits between a core-side or DMA-side client and the uncore AHB fabric, driving the same bus that the on-chip RAM and peripherals answer. One transfer's address phase overlaps the previous transfer's data phase, so zero-wait subordinates sustain one transfer per cycle.

## Interface
- P: cvw_t configuration; supplies P.PA_BITS and P.XLEN.
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- ReqValid  in  1  client request present.
- ReqReady  out  1  request accepted this cycle when ReqValid & ReqReady.
- ReqAddr  in  P.PA_BITS  byte address.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqSize  in  3  HSIZE encoding, at most log2(P.XLEN/8).
- ReqWData  in  P.XLEN  write data.
- ReqStrb  in  P.XLEN/8  write byte strobes.
- RspValid  out  1  one-cycle pulse, one per accepted request, in request order.
- RspRData  out  P.XLEN  read data; 0 for writes and errors.
- RspErr  out  1  transfer ended with HRESP = 1.
- ErrSticky  out  1  set by any error response; held until ErrClr.
- ErrClr  in  1  synchronous clear of ErrSticky.
- HADDR  out  P.PA_BITS; HWRITE  out  1; HSIZE  out  3; HTRANS  out  2; HBURST  out  3 (tied SINGLE 3'b000); HPROT  out  4 (tied 4'b0011); HMASTLOCK  out  1 (tied 0).
- HWDATA  out  P.XLEN; HWSTRB  out  P.XLEN/8.
- HREADY  in  1  bus ready (mux output, not a per-subordinate ready).
- HRDATA  in  P.XLEN; HRESP  in  1.

## Operation
- Two pipeline registers: address stage (AValid, addr, write, size, wdata, strb) and data stage (DValid, write, wdata, strb).
- State is the pair {AValid, DValid}, named IDLE (0,0), ADDR (1,0), PIPE (1,1), DATA (0,1).
- HTRANS = NONSEQ (2'b10) when AValid, else IDLE (2'b00). HADDR/HWRITE/HSIZE come from the address stage. HWDATA/HWSTRB come from the data stage; they are 0 when ~DValid or a read is in the data stage.
- ReqReady = ~AValid | HREADY (combinational). On acceptance, the request loads into the address stage.
- On HREADY = 1:
  - The data stage completes.
  - The address stage advances to the data stage.
  - The address stage reloads from an accepted request or clears.
- On HREADY = 0: both stages and all bus outputs hold.
- Completion with DValid & HREADY registers RspValid = 1, RspErr = HRESP, and RspRData = HRDATA for an error-free read, else 0.
- Error: the first error cycle (HRESP = 1, HREADY = 0) holds the pipeline. The pending address phase is not cancelled and is issued normally afterwards.
- ErrSticky sets on a completion with HRESP = 1. ErrClr in the same cycle loses to the set.

## Timing
- Zero-wait latency: accept at cycle N, address phase at N+1, data phase at N+2, RspValid at N+3. Each wait state adds one cycle.
- Throughput: one transfer per cycle with HREADY held high; no idle cycles between back-to-back accepted requests.
- Reset values: HTRANS = IDLE, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0, HWSTRB = 0, RspValid = 0, RspRData = 0, RspErr = 0, ErrSticky = 0, AValid = DValid = 0, ReqReady = 1.
- Reset mid-transfer: all state clears asynchronously. In-flight transfers are dropped with no response, and HTRANS goes IDLE immediately.
- There is no response backpressure. The client must sink RspValid every cycle.

## Structure
- The shared cvw package holds:
  - AHB constants: AHB_HTRANS_IDLE = 2'b00, AHB_HTRANS_NONSEQ = 2'b10, AHB_HBURST_SINGLE = 3'b000.
  - The manager state enum {IDLE, ADDR, PIPE, DATA}.
- All storage uses async-reset, active-low flops with enable.
- No sub-module is needed beyond the flop primitives. The stage registers are instantiated inline.

## Test plan
- Single write: addr 0x80000010, data 0xDEADBEEF, strb 0xF, zero-wait -> HTRANS NONSEQ one cycle, HWDATA = 0xDEADBEEF on the next cycle, RspValid with RspErr = 0 three cycles after acceptance.
- Read with 2 wait states: HRDATA = 0x12345678 on the final HREADY cycle -> RspRData = 0x12345678 five cycles after acceptance; bus outputs stable throughout the wait.
- Four back-to-back reads, zero-wait -> four consecutive NONSEQ cycles, four consecutive RspValid pulses in order, ReqReady never low.
- Write then read to the same address, with the subordinate inserting one wait on the read -> write data is driven during the read's address phase, and the read response follows the write by 2 cycles.
- Error: HRESP = 1 for two cycles (HREADY 0 then 1) on the first of two requests -> first response has RspErr = 1 and RspRData = 0, ErrSticky = 1, second transfer completes normally, ErrClr drops ErrSticky.
- HRESETn asserted while in PIPE -> HTRANS = IDLE the same cycle, no RspValid, ReqReady = 1 after release.
